nibble_pair_capture: RTL and testbench
======================================

# nibble_pair_capture

Sequencer and capture register that sits directly downstream of the quad 2-to-1 nibble mux. It drives the mux's active-low enable `E` and select `S`, samples the mux output `Y` once with `S=0` (A side) and once with `S=1` (B side), and assembles the two nibbles into one byte for the datapath. A per-byte counter and a one-cycle completion strobe let the consumer count and accept results.

## Interface
- `SETTLE`, default 2: cycles each select setting is held before `Y` is sampled; legal range 1..15.
- `CLK`  in  1  single clock; all state changes on rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `START`  in  1  request one byte capture; sampled only in IDLE.
- `Y`  in  4  mux output nibble {Y3,Y2,Y1,Y0}.
- `E`  out  1  mux enable, active-low; drives mux `E`.
- `S`  out  1  mux select; 0 = A side, 1 = B side.
- `BUSY`  out  1  high from the SEL_A state through the FIN state.
- `DONE`  out  1  one-cycle strobe; `DOUT` is valid while it is high.
- `DOUT`  out  8  {B nibble, A nibble}; holds its value until the next capture or reset.
- `NBYTES`  out  8  count of completed captures; wraps from 255 to 0.

## Operation
- All outputs are registered. Internal state: 2-bit FSM state, 4-bit settle counter `cnt`, 4-bit low-nibble holding register `lo`.
- **Reset** (RST=1 at an edge, in any state, including mid-capture):
  - FSM goes to IDLE; `cnt` = 0; `lo` = 0.
  - Outputs: `E`=1, `S`=0, `BUSY`=0, `DONE`=0, `DOUT`=8'h00, `NBYTES`=8'h00.
  - `RST` has priority over `START`.
- **IDLE**: `E`=1 (mux disabled), `S`=0, `BUSY`=0.
  - If `START`=1, go to SEL_A and set `cnt`=0.
- **SEL_A**: `E`=0, `S`=0, `BUSY`=1.
  - `cnt` increments each cycle.
  - At the edge where `cnt`==SETTLE-1: `lo` <= `Y`, `cnt` <= 0, go to SEL_B.
- **SEL_B**: `E`=0, `S`=1, `BUSY`=1.
  - At the edge where `cnt`==SETTLE-1: `DOUT` <= {`Y`, `lo`}, `NBYTES` <= `NBYTES`+1 (mod 256), go to FIN.
- **FIN**: `E`=1, `S`=0, `BUSY`=1, `DONE`=1 for exactly this one cycle. Next state is IDLE unconditionally.
- `START` is ignored outside IDLE: no queuing, no restart, no effect on `DOUT` or `NBYTES`.
- `START` held high continuously produces back-to-back captures with one IDLE cycle between them.
- `Y` is ignored in every cycle except the two sampling edges.
- Both `E` and `S` are registered from the state, so they never glitch.

## Timing
- Let `START`=1 be sampled at edge t0 (state IDLE).
- `E`=0, `S`=0 from t0 through t0+SETTLE.
- `S`=1 from t0+SETTLE through t0+2·SETTLE.
- A nibble is sampled at edge t0+SETTLE. B nibble is sampled at edge t0+2·SETTLE.
- `DONE`=1 and the new `DOUT`/`NBYTES` are visible in the cycle after edge t0+2·SETTLE.
- State is back to IDLE after edge t0+2·SETTLE+1.
- Start-to-DONE latency is 2·SETTLE+1 edges. Minimum start-to-start period is 2·SETTLE+2 cycles.
- The upstream mux is combinational, so `Y` must be stable at each sampling edge. SETTLE≥1 guarantees at least one full cycle after each select change.

## Test plan
- **Reset values**: drive RST=1 for 2 cycles, with START=1 during reset. Required: `E`=1, `S`=0, `BUSY`=0, `DONE`=0, `DOUT`=00, `NBYTES`=00; no capture starts.
- **Basic capture** (SETTLE=2): A side = 4'h5, B side = 4'hA, one-cycle START. Required:
  - `S` low for 2 cycles, then high for 2 cycles.
  - `DONE` high exactly at edge 5 after START.
  - `DOUT`=8'hA5, `NBYTES`=1.
- **Busy masking**: pulse START again during SEL_B. Required: only one `DONE`; `NBYTES` increments by exactly 1; `DOUT` unchanged afterwards.
- **Reset mid-operation**: assert RST in SEL_B after a prior byte 8'h3C has been captured. Required: next cycle IDLE, `DOUT`=00, `NBYTES`=00, `E`=1; a following START captures normally.
- **Back-to-back with wrap** (SETTLE=1): START held high, A=4'hF, B=4'h0. Required:
  - `DONE` every 4 cycles with `DOUT`=8'h0F.
  - After 256 captures `NBYTES` reads 00.
- **Y isolation**: change `Y` every cycle except the two sampling edges. Required: `DOUT` reflects only the values present at the sampling edges.

Source files
------------

// File: rtl/nibble_pair_capture.sv
// nibble_pair_capture
// Drives the enable and select of an upstream quad 2-to-1 nibble mux and
// samples its output twice: once with the A side selected and once with the
// B side selected. The two nibbles are packed into one byte.
//
// State table:
//   state | meaning
//   IDLE  | mux disabled, waiting for START
//   SEL_A | A side selected, settling, A nibble sampled on the last settle edge
//   SEL_B | B side selected, settling, byte assembled on the last settle edge
//   FIN   | mux disabled, DONE strobe for one cycle, DOUT/NBYTES valid
//
// Ports:
//   CLK    in   clock, all state changes on the rising edge
//   RST    in   synchronous active-high reset, priority over START
//   START  in   request one byte capture, only looked at in IDLE
//   Y      in   [3:0] mux output nibble
//   E      out  mux enable, active-low
//   S      out  mux select, 0 = A side, 1 = B side
//   BUSY   out  high from SEL_A through FIN
//   DONE   out  one-cycle completion strobe
//   DOUT   out  [7:0] {B nibble, A nibble}, held until the next capture
//   NBYTES out  [7:0] completed capture count, wraps 255 -> 0
//
// SETTLE (1..15) is the number of cycles each select setting is held before Y
// is sampled.

module nibble_pair_capture #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [3:0] Y,
  output logic       E,
  output logic       S,
  output logic       BUSY,
  output logic       DONE,
  output logic [7:0] DOUT,
  output logic [7:0] NBYTES
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEL_A = 2'd1,
    SEL_B = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [3:0] lo, lo_nxt;
  logic [7:0] dout_nxt, nbytes_nxt;
  logic       e_nxt, s_nxt, busy_nxt, done_nxt;
  logic       settle_done;

  assign settle_done = (cnt == CNT_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      lo     <= 4'd0;
      E      <= 1'b1;
      S      <= 1'b0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      DOUT   <= 8'h00;
      NBYTES <= 8'h00;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      lo     <= lo_nxt;
      E      <= e_nxt;
      S      <= s_nxt;
      BUSY   <= busy_nxt;
      DONE   <= done_nxt;
      DOUT   <= dout_nxt;
      NBYTES <= nbytes_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    lo_nxt     = lo;
    dout_nxt   = DOUT;
    nbytes_nxt = NBYTES;
    case (state)
      IDLE: begin
        if (START) begin
          state_nxt = SEL_A;
          cnt_nxt   = 4'd0;
        end
      end
      SEL_A: begin
        if (settle_done) begin
          lo_nxt    = Y;
          cnt_nxt   = 4'd0;
          state_nxt = SEL_B;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      SEL_B: begin
        if (settle_done) begin
          dout_nxt   = {Y, lo};
          nbytes_nxt = NBYTES + 8'd1;
          cnt_nxt    = 4'd0;
          state_nxt  = FIN;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so each output
  // lines up with the state it belongs to and cannot glitch.
  always_comb begin
    e_nxt    = (state_nxt == IDLE) || (state_nxt == FIN);
    s_nxt    = (state_nxt == SEL_B);
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == FIN);
  end

endmodule

// File: tb/tb_nibble_pair_capture.sv
module tb_nibble_pair_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // index 0: SETTLE=2 instance, index 1: SETTLE=1 instance
  logic       rst_i[2];
  logic       start_i[2];
  logic [3:0] y_i[2];
  logic       e_o[2], s_o[2], busy_o[2], done_o[2];
  logic [7:0] dout_o[2], nb_o[2];

  nibble_pair_capture #(.SETTLE(2)) u_s2 (
    .CLK(clk), .RST(rst_i[0]), .START(start_i[0]), .Y(y_i[0]),
    .E(e_o[0]), .S(s_o[0]), .BUSY(busy_o[0]), .DONE(done_o[0]),
    .DOUT(dout_o[0]), .NBYTES(nb_o[0])
  );

  nibble_pair_capture #(.SETTLE(1)) u_s1 (
    .CLK(clk), .RST(rst_i[1]), .START(start_i[1]), .Y(y_i[1]),
    .E(e_o[1]), .S(s_o[1]), .BUSY(busy_o[1]), .DONE(done_o[1]),
    .DOUT(dout_o[1]), .NBYTES(nb_o[1])
  );

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: a capture is described only by the edge t0 at which
  // START was accepted; everything else follows from edge arithmetic.
  int         edge_n = 0;
  int         t0[2] = '{-1, -1};
  int         st[2] = '{2, 1};
  logic [3:0] ma[2];
  logic [7:0] mdout[2];
  logic [7:0] mnb[2];

  logic       mux_mode[2];
  logic [3:0] a_nib[2], b_nib[2];

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", tag, got, exp);
  endtask

  task automatic model_edge(input int i, input logic r, input logic go, input logic [3:0] y);
    int s;
    s = st[i];
    if (r) begin
      t0[i]    = -1;
      mdout[i] = 8'h00;
      mnb[i]   = 8'h00;
    end else begin
      if (t0[i] >= 0 && edge_n == t0[i] + s) ma[i] = y;
      if (t0[i] >= 0 && edge_n == t0[i] + 2 * s) begin
        mdout[i] = {y, ma[i]};
        mnb[i]   = mnb[i] + 8'd1;
      end
      if ((t0[i] < 0 || edge_n - t0[i] >= 2 * s + 2) && go) t0[i] = edge_n;
    end
  endtask

  task automatic check_all(input int i);
    int   s, d;
    logic act;
    s   = st[i];
    d   = edge_n - t0[i];
    act = (t0[i] >= 0) && (d <= 2 * s);
    chk($sformatf("i%0d_E@%0d", i, edge_n), {7'd0, e_o[i]}, {7'd0, !(act && d < 2 * s)});
    chk($sformatf("i%0d_S@%0d", i, edge_n), {7'd0, s_o[i]}, {7'd0, act && d >= s && d < 2 * s});
    chk($sformatf("i%0d_BUSY@%0d", i, edge_n), {7'd0, busy_o[i]}, {7'd0, act});
    chk($sformatf("i%0d_DONE@%0d", i, edge_n), {7'd0, done_o[i]}, {7'd0, act && d == 2 * s});
    chk($sformatf("i%0d_DOUT@%0d", i, edge_n), dout_o[i], mdout[i]);
    chk($sformatf("i%0d_NBYTES@%0d", i, edge_n), nb_o[i], mnb[i]);
  endtask

  // Upstream mux: disabled outputs 0, otherwise the selected side.
  task automatic drive_y(input int i);
    y_i[i] = e_o[i] ? 4'h0 : (s_o[i] ? b_nib[i] : a_nib[i]);
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    model_edge(0, rst_i[0], start_i[0], y_i[0]);
    model_edge(1, rst_i[1], start_i[1], y_i[1]);
    #1;
    check_all(0);
    check_all(1);
    for (int i = 0; i < 2; i++) if (mux_mode[i]) drive_y(i);
  endtask

  initial begin
    int         done_at, ndone, last_done;
    logic [7:0] v8;

    for (int i = 0; i < 2; i++) begin
      rst_i[i] = 1'b1; start_i[i] = 1'b1; y_i[i] = 4'( $urandom);
      mux_mode[i] = 1'b0; a_nib[i] = 4'h0; b_nib[i] = 4'h0;
      ma[i] = 4'h0; mdout[i] = 8'h00; mnb[i] = 8'h00;
    end

    // reset with START high
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin rst_i[i] = 1'b0; start_i[i] = 1'b0; end
    tick();
    chk("reset_no_capture", {7'd0, busy_o[0]}, 8'd0);

    // basic capture, SETTLE=2, A=5 B=A
    mux_mode[0] = 1'b1; a_nib[0] = 4'h5; b_nib[0] = 4'hA; drive_y(0);
    start_i[0] = 1'b1;
    tick();
    start_i[0] = 1'b0;
    done_at = 0;
    for (int k = 2; k <= 10; k++) begin
      tick();
      if (done_o[0] && done_at == 0) done_at = k;
    end
    chk("basic_done_edge", 8'(done_at), 8'd5);
    chk("basic_dout", dout_o[0], 8'hA5);
    chk("basic_nbytes", nb_o[0], 8'd1);

    // START pulses during SEL_B are ignored
    start_i[0] = 1'b1;
    tick();
    start_i[0] = 1'b0;
    tick();
    tick();
    start_i[0] = 1'b1;
    ndone = 0;
    for (int k = 4; k <= 12; k++) begin
      tick();
      if (k == 5) start_i[0] = 1'b0;
      if (done_o[0]) ndone++;
    end
    chk("mask_done_count", 8'(ndone), 8'd1);
    chk("mask_nbytes", nb_o[0], 8'd2);
    chk("mask_dout", dout_o[0], 8'hA5);

    // capture 3C, then reset in SEL_B
    a_nib[0] = 4'hC; b_nib[0] = 4'h3;
    start_i[0] = 1'b1;
    tick();
    start_i[0] = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    chk("pre_rst_dout", dout_o[0], 8'h3C);
    start_i[0] = 1'b1;
    tick();
    start_i[0] = 1'b0;
    tick();
    tick();
    rst_i[0] = 1'b1;
    tick();
    rst_i[0] = 1'b0;
    chk("midrst_dout", dout_o[0], 8'h00);
    chk("midrst_nbytes", nb_o[0], 8'h00);
    chk("midrst_e", {7'd0, e_o[0]}, 8'd1);
    a_nib[0] = 4'h7; b_nib[0] = 4'h2;
    start_i[0] = 1'b1;
    tick();
    start_i[0] = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    chk("post_rst_dout", dout_o[0], 8'h27);
    chk("post_rst_nbytes", nb_o[0], 8'h01);

    // back-to-back with wrap, SETTLE=1, START held
    mux_mode[1] = 1'b1; a_nib[1] = 4'hF; b_nib[1] = 4'h0; drive_y(1);
    start_i[1] = 1'b1;
    ndone = 0;
    last_done = -1;
    for (int k = 0; k < 256 * 4 + 20 && ndone < 256; k++) begin
      tick();
      if (done_o[1]) begin
        ndone++;
        if (last_done >= 0) chk("b2b_period", 8'(k - last_done), 8'd4);
        chk("b2b_dout", dout_o[1], 8'h0F);
        last_done = k;
      end
    end
    chk("b2b_256_done", {7'd0, ndone == 256}, 8'd1);
    chk("b2b_wrap_nbytes", nb_o[1], 8'h00);
    start_i[1] = 1'b0;
    for (int k = 0; k < 6; k++) tick();

    // random START/RST with Y changing every cycle
    mux_mode[0] = 1'b0;
    mux_mode[1] = 1'b0;
    for (int k = 0; k < 800; k++) begin
      for (int i = 0; i < 2; i++) begin
        rst_i[i]   = ($urandom_range(0, 79) == 0);
        start_i[i] = ($urandom_range(0, 2) == 0);
        v8         = 8'($urandom);
        y_i[i]     = v8[3:0];
      end
      tick();
    end
    for (int i = 0; i < 2; i++) begin rst_i[i] = 1'b0; start_i[i] = 1'b0; end
    for (int k = 0; k < 8; k++) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
